fp_minmax_cmp_pipe: RTL and testbench

Parametrised successor to the single-precision min/max unit.
- Supports FMIN, FMAX, FEQ, FLT and FLE for any IEEE-754 binary format.
- Two-stage pipeline with a valid/ready handshake and full backpressure.
- Follows RISC-V F-extension NaN, signed-zero and invalid-flag semantics exactly.
- Sits between the FP issue stage and the writeback/round path; tag_i carries the destination ID through.

---
 rtl/fp_minmax_cmp_pipe.sv | 162 ++++++++++++++++
 tb/tb_fp_minmax_cmp_pipe.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_minmax_cmp_pipe.sv
// fp_minmax_cmp_pipe: IEEE-754 FMIN/FMAX/FEQ/FLT/FLE with RISC-V NaN, signed-zero and NV rules.
// Latency: 2 cycles with no stalls (stage 1 classify + magnitude compare, stage 2 select); 1 op/cycle.
// Backpressure: ready_o = adv1 (never depends on valid_i); outputs hold stable while valid_o & !ready_i.
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o + operand_a_i/operand_b_i/operation_i/tag_i in;
//        valid_o/ready_i + result_o/tag_o/invalid_op_o out (invalid_op_o qualified by valid_o).
module fp_minmax_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [EXP_W+MAN_W:0]   operand_a_i,
  input  logic [EXP_W+MAN_W:0]   operand_b_i,
  input  logic [2:0]             operation_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [TAG_W-1:0]       tag_o,
  output logic                   invalid_op_o
);

  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_FMIN = 3'd0;
  localparam logic [2:0] OP_FMAX = 3'd1;
  localparam logic [2:0] OP_FEQ  = 3'd2;
  localparam logic [2:0] OP_FLT  = 3'd3;
  localparam logic [2:0] OP_FLE  = 3'd4;

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Infinities are not tracked: their order falls out of the unsigned magnitude compare.
  typedef struct packed {
    logic zero;
    logic nan;
    logic snan;
  } cls_t;

  function automatic cls_t classify(input logic [W-2:0] mag);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    cls_t             c;
    e      = mag[W-2:MAN_W];
    m      = mag[MAN_W-1:0];
    c.zero = (e == '0) && (m == '0);
    c.nan  = (&e) && (m != '0);
    c.snan = c.nan && !m[MAN_W-1];
    return c;
  endfunction

  // Pipeline control
  logic s1_valid, s2_valid, adv1, adv2;

  assign adv2    = !s2_valid || ready_i;
  assign adv1    = !s1_valid || adv2;
  assign ready_o = adv1;
  assign valid_o = s2_valid;

  // Stage 1: operands, classification, magnitude compare, sideband
  logic [W-1:0]     s1_a, s1_b;
  cls_t             s1_ca, s1_cb;
  logic             s1_lt_mag, s1_eq_mag;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ca     <= '0;
      s1_cb     <= '0;
      s1_lt_mag <= 1'b0;
      s1_eq_mag <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
    end else if (adv1) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_a      <= operand_a_i;
        s1_b      <= operand_b_i;
        s1_ca     <= classify(operand_a_i[W-2:0]);
        s1_cb     <= classify(operand_b_i[W-2:0]);
        s1_lt_mag <= operand_a_i[W-2:0] <  operand_b_i[W-2:0];
        s1_eq_mag <= operand_a_i[W-2:0] == operand_b_i[W-2:0];
        s1_op     <= operation_i;
        s1_tag    <= tag_i;
      end
    end
  end

  // Stage 2 select
  logic         sa, sb, any_nan, any_snan, both_zero, a_lt_b, a_eq_b;
  logic [W-1:0] nxt_res;
  logic         nxt_nv;

  always_comb begin
    sa        = s1_a[W-1];
    sb        = s1_b[W-1];
    any_nan   = s1_ca.nan  | s1_cb.nan;
    any_snan  = s1_ca.snan | s1_cb.snan;
    both_zero = s1_ca.zero & s1_cb.zero;
    // a_lt_b / a_eq_b are only meaningful for non-NaN pairs; NaN is masked at use.
    a_eq_b    = !any_nan && (both_zero || ((sa == sb) && s1_eq_mag));
    if (both_zero)      a_lt_b = 1'b0;
    else if (sa != sb)  a_lt_b = sa;
    else if (!sa)       a_lt_b = s1_lt_mag;
    else                a_lt_b = !s1_lt_mag && !s1_eq_mag;

    nxt_res = '0;
    nxt_nv  = 1'b0;
    case (s1_op)
      OP_FMIN, OP_FMAX: begin
        nxt_nv = any_snan;
        if (s1_ca.nan && s1_cb.nan) nxt_res = CANON_NAN;
        else if (s1_ca.nan)         nxt_res = s1_b;
        else if (s1_cb.nan)         nxt_res = s1_a;
        // +0 vs -0: FMIN picks the negative one, FMAX the positive one.
        else if (both_zero)         nxt_res = ((s1_op == OP_FMIN) == sa) ? s1_a : s1_b;
        else if (s1_op == OP_FMIN)  nxt_res = (a_lt_b || a_eq_b) ? s1_a : s1_b;
        else                        nxt_res = a_lt_b ? s1_b : s1_a;
      end
      OP_FEQ: begin
        nxt_res = {{(W-1){1'b0}}, a_eq_b};
        nxt_nv  = any_snan;
      end
      OP_FLT: begin
        nxt_res = {{(W-1){1'b0}}, a_lt_b && !any_nan};
        nxt_nv  = any_nan;
      end
      OP_FLE: begin
        nxt_res = {{(W-1){1'b0}}, (a_lt_b || a_eq_b) && !any_nan};
        nxt_nv  = any_nan;
      end
      default: begin
        nxt_res = '0;
        nxt_nv  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid     <= 1'b0;
      result_o     <= '0;
      tag_o        <= '0;
      invalid_op_o <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o     <= nxt_res;
        tag_o        <= s1_tag;
        invalid_op_o <= nxt_nv;
      end
    end
  end

endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
// tb_fp_minmax_cmp_pipe: directed checks of fp_minmax_cmp_pipe at single and double precision.
// Expected results are queued at input accept and compared when the DUT hands a result over.
// Backpressure: ready_i is stalled in one phase; held outputs are checked for stability.
module tb_fp_minmax_cmp_pipe;

  localparam logic [2:0] FMIN = 3'd0, FMAX = 3'd1, FEQ = 3'd2, FLT = 3'd3, FLE = 3'd4;

  logic clk;
  logic rst_i;

  // single-precision instance
  logic        valid_i, ready_o, valid_o, ready_i, invalid_op_o;
  logic [31:0] operand_a_i, operand_b_i, result_o;
  logic [2:0]  operation_i;
  logic [4:0]  tag_i, tag_o;

  // double-precision instance
  logic        d_valid_i, d_ready_o, d_valid_o, d_ready_i, d_nv;
  logic [63:0] d_a, d_b, d_res;
  logic [2:0]  d_op;
  logic [4:0]  d_tag_i, d_tag_o;

  fp_minmax_cmp_pipe u32 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operation_i(operation_i),
    .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .tag_o(tag_o), .invalid_op_o(invalid_op_o)
  );

  fp_minmax_cmp_pipe #(.EXP_W(11), .MAN_W(52), .TAG_W(5)) u64 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(d_valid_i), .ready_o(d_ready_o),
    .operand_a_i(d_a), .operand_b_i(d_b), .operation_i(d_op),
    .tag_i(d_tag_i), .valid_o(d_valid_o), .ready_i(d_ready_i), .result_o(d_res),
    .tag_o(d_tag_o), .invalid_op_o(d_nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        nv;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  int n_cmp = 0;
  int n_err = 0;
  int out32 = 0;
  int stall_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $display("FAIL %s: observed=%h expected=%h", nm, obs, exp_v);
      $error("mismatch on %s", nm);
    end
  endtask

  // Output monitors: pop on handshake, check held values while stalled.
  logic        h_pend = 1'b0;
  logic [31:0] h_res;
  logic [4:0]  h_tag;
  logic        h_nv;

  always @(negedge clk) begin
    exp_t e;
    if (!ready_o) stall_cnt++;
    if (h_pend) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_result", result_o, h_res);
      chk("hold_tag", tag_o, h_tag);
      chk("hold_nv", invalid_op_o, h_nv);
    end
    if (valid_o && ready_i) begin
      if (q32.size() == 0) chk("spurious_out32", valid_o, 0);
      else begin
        e = q32.pop_front();
        out32++;
        chk("result32", result_o, e.res);
        chk("tag32", tag_o, e.tag);
        chk("nv32", invalid_op_o, e.nv);
      end
    end
    h_pend = valid_o && !ready_i && !rst_i;
    h_res  = result_o;
    h_tag  = tag_o;
    h_nv   = invalid_op_o;
  end

  always @(negedge clk) begin
    exp_t e;
    if (d_valid_o && d_ready_i) begin
      if (q64.size() == 0) chk("spurious_out64", d_valid_o, 0);
      else begin
        e = q64.pop_front();
        chk("result64", d_res, e.res);
        chk("tag64", d_tag_o, e.tag);
        chk("nv64", d_nv, e.nv);
      end
    end
  end

  // Drive at #1 after a posedge; returns #1 after the accepting edge.
  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [4:0] tg, input logic [31:0] er, input logic en,
                        input logic push, output int waited);
    exp_t e;
    valid_i = 1'b1; operand_a_i = a; operand_b_i = b; operation_i = op; tag_i = tg;
    waited = 0;
    @(negedge clk);
    while (!ready_o && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) chk("send32_accept", ready_o, 1);
    e.res = {32'd0, er}; e.tag = tg; e.nv = en;
    if (push) q32.push_back(e);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                        input logic [4:0] tg, input logic [63:0] er, input logic en);
    exp_t e;
    int   w;
    d_valid_i = 1'b1; d_a = a; d_b = b; d_op = op; d_tag_i = tg;
    w = 0;
    @(negedge clk);
    while (!d_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!d_ready_o) chk("send64_accept", d_ready_o, 1);
    e.res = er; e.tag = tg; e.nv = en;
    q64.push_back(e);
    @(posedge clk); #1;
    d_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (q32.size() != 0 || q64.size() != 0); i++) @(negedge clk);
    #1;
    chk("drain32", q32.size(), 0);
    chk("drain64", q64.size(), 0);
  endtask

  // Reference max for positive, non-NaN single-precision values: integer order equals value order.
  function automatic logic [31:0] fmax_pos(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [31:0] sa_tab [6];
  logic [31:0] sb_tab [6];

  initial begin
    int wt;
    int base;
    rst_i = 1'b1; ready_i = 1'b1; d_ready_i = 1'b1;
    valid_i = 1'b0; operand_a_i = '0; operand_b_i = '0; operation_i = '0; tag_i = '0;
    d_valid_i = 1'b0; d_a = '0; d_b = '0; d_op = '0; d_tag_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_nv", invalid_op_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid64", d_valid_o, 0);
    @(posedge clk); #1;

    // First op and its latency
    send32(32'h3F800000, 32'hC0000000, FMIN, 5'd3, 32'hC0000000, 1'b0, 1'b1, wt);
    @(negedge clk);
    chk("lat_cycle1_valid", valid_o, 0);
    @(negedge clk);
    chk("lat_cycle2_valid", valid_o, 1);
    @(posedge clk); #1;

    // Signed zeros, NaNs, ordering, reserved opcode
    send32(32'h00000000, 32'h80000000, FMAX, 5'd4, 32'h00000000, 1'b0, 1'b1, wt);
    send32(32'h00000000, 32'h80000000, FMIN, 5'd5, 32'h80000000, 1'b0, 1'b1, wt);
    send32(32'h00000000, 32'h80000000, FEQ,  5'd6, 32'h00000001, 1'b0, 1'b1, wt);
    send32(32'h7FA00000, 32'h40400000, FMAX, 5'd7, 32'h40400000, 1'b1, 1'b1, wt);
    send32(32'hFFC00001, 32'h7FC00000, FMIN, 5'd8, 32'h7FC00000, 1'b0, 1'b1, wt);
    send32(32'h7FC00000, 32'h3F800000, FLT,  5'd9, 32'h00000000, 1'b1, 1'b1, wt);
    send32(32'h7FC00000, 32'h3F800000, FEQ,  5'd10, 32'h00000000, 1'b0, 1'b1, wt);
    send32(32'h3F800000, 32'h3F800000, FLE,  5'd11, 32'h00000001, 1'b0, 1'b1, wt);
    send32(32'hBF800000, 32'h3F800000, FLT,  5'd12, 32'h00000001, 1'b0, 1'b1, wt);
    send32(32'hC0400000, 32'hC0000000, FMIN, 5'd13, 32'hC0400000, 1'b0, 1'b1, wt);
    send32(32'h7F800000, 32'h3F800000, FMAX, 5'd14, 32'h7F800000, 1'b0, 1'b1, wt);
    send32(32'h80000000, 32'h00000000, FMAX, 5'd15, 32'h00000000, 1'b0, 1'b1, wt);
    send32(32'h3F800000, 32'h3F800000, 3'd5, 5'd16, 32'h00000000, 1'b1, 1'b1, wt);
    send32(32'hC0000000, 32'hBF800000, FLE,  5'd17, 32'h00000001, 1'b0, 1'b1, wt);
    send32(32'h3F800000, 32'h3F800000, FLT,  5'd18, 32'h00000000, 1'b0, 1'b1, wt);
    send32(32'h00000000, 32'h80000000, FLE,  5'd19, 32'h00000001, 1'b0, 1'b1, wt);
    wait_drain();

    // Full-rate throughput with ready_i high
    @(posedge clk); #1;
    base = out32;
    for (int k = 0; k < 4; k++) begin
      send32(32'h40000000 + 32'(k), 32'h40000002, FMAX, 5'(k), fmax_pos(32'h40000000 + 32'(k), 32'h40000002),
             1'b0, 1'b1, wt);
      chk("tput_no_wait", wt, 0);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("tput_count", out32 - base, 4);
    @(negedge clk);
    chk("tput_empty", valid_o, 0);
    @(posedge clk); #1;

    // Backpressure: ready_i low for cycles 3-6 of a 6-op FMAX stream
    sa_tab = '{32'h3F800000, 32'h40400000, 32'h41200000, 32'h00000001, 32'h7F7FFFFF, 32'h3E800000};
    sb_tab = '{32'h40000000, 32'h3F000000, 32'h41200001, 32'h00000000, 32'h7F800000, 32'h3E800000};
    base = stall_cnt;
    fork
      begin
        int wt2;
        for (int k = 0; k < 6; k++)
          send32(sa_tab[k], sb_tab[k], FMAX, 5'd20 + 5'(k), fmax_pos(sa_tab[k], sb_tab[k]), 1'b0, 1'b1, wt2);
      end
      begin
        repeat (2) @(posedge clk);
        #1 ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 ready_i = 1'b1;
      end
    join
    wait_drain();
    chk("bp_ready_dropped", (stall_cnt - base) > 0, 1);

    // Reset with two ops in flight
    @(posedge clk); #1;
    ready_i = 1'b0;
    send32(32'h3F800000, 32'h40000000, FMIN, 5'd1, 32'h0, 1'b0, 1'b0, wt);
    send32(32'h40400000, 32'h40000000, FMAX, 5'd2, 32'h0, 1'b0, 1'b0, wt);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_result", result_o, 0);
    chk("midrst_tag", tag_o, 0);
    chk("midrst_nv", invalid_op_o, 0);
    chk("midrst_ready", ready_o, 1);
    @(posedge clk); #1;
    send32(32'hC1200000, 32'h41200000, FMAX, 5'd30, 32'h41200000, 1'b0, 1'b1, wt);
    @(negedge clk);
    chk("postrst_lat1", valid_o, 0);
    @(negedge clk);
    chk("postrst_lat2", valid_o, 1);
    wait_drain();

    // Reset coincident with valid_i: the op must not be captured
    @(posedge clk); #1;
    rst_i = 1'b1; valid_i = 1'b1;
    operand_a_i = 32'h3F800000; operand_b_i = 32'h40000000; operation_i = FMIN; tag_i = 5'd31;
    @(posedge clk); #1;
    rst_i = 1'b0; valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_with_valid_out", valid_o, 0);
    end

    // Double precision
    @(posedge clk); #1;
    send64(64'hFFF0000000000000, 64'hC000000000000000, FLE,  5'd1, 64'h1, 1'b0);
    send64(64'h3FF0000000000000, 64'h3FF0000000000000, 3'd6, 5'd2, 64'h0, 1'b1);
    send64(64'h3FF0000000000000, 64'h7FF8000000000000, FMIN, 5'd3, 64'h3FF0000000000000, 1'b0);
    send64(64'h7FF8000000000001, 64'hFFF8000000000000, FMAX, 5'd4, 64'h7FF8000000000000, 1'b0);
    send64(64'h8000000000000000, 64'h0000000000000000, FMIN, 5'd5, 64'h8000000000000000, 1'b0);
    send64(64'h7FF0000000000001, 64'h4000000000000000, FLT,  5'd6, 64'h0, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
